// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-enable divider, H/V counters and a
// registered colour/sync output stage. Define VGA_TEST_PATTERN_EN for built-in colour bars.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic        Clock,
    input  logic        Reset_N,
    input  logic [11:0] Color_In,
    output logic [9:0]  Pixel_X,
    output logic [9:0]  Pixel_Y,
    output logic        Pixel_Valid,
    output logic        Pix_En,
    output logic        Frame_Start,
    output logic [3:0]  RED,
    output logic [3:0]  GREEN,
    output logic [3:0]  BLUE,
    output logic        H_Sync,
    output logic        V_Sync
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned RGB_W   = 12;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_LO   = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_HI   = HS_LO + H_SYNC;
    localparam int unsigned VS_LO   = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_HI   = VS_LO + V_SYNC;

    logic             x_last_c;
    logic             y_last_c;
    logic             h_active_c;
    logic             v_active_c;
    logic [RGB_W-1:0] src_color_c;
    logic [RGB_W-1:0] rgb_c;

    // Pixel-rate strobe: 50 MHz board clock halved to 25 MHz
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) Pix_En <= 1'b0;
        else          Pix_En <= ~Pix_En;
    end

    assign x_last_c    = (Pixel_X == CNT_W'(H_TOTAL - 1));
    assign y_last_c    = (Pixel_Y == CNT_W'(V_TOTAL - 1));
    assign Pixel_Valid = (Pixel_X < CNT_W'(H_VISIBLE)) && (Pixel_Y < CNT_W'(V_VISIBLE));
    assign h_active_c  = (Pixel_X >= CNT_W'(HS_LO)) && (Pixel_X < CNT_W'(HS_HI));
    assign v_active_c  = (Pixel_Y >= CNT_W'(VS_LO)) && (Pixel_Y < CNT_W'(VS_HI));

    // Stage 0: raster counters and frame-wrap pulse
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            Pixel_X     <= '0;
            Pixel_Y     <= '0;
            Frame_Start <= 1'b0;
        end else begin
            Frame_Start <= Pix_En && x_last_c && y_last_c;
            if (Pix_En) begin
                Pixel_X <= x_last_c ? '0 : Pixel_X + CNT_W'(1);
                if (x_last_c) Pixel_Y <= y_last_c ? '0 : Pixel_Y + CNT_W'(1);
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_c;
    logic       color_in_unused;

    assign color_in_unused = ^Color_In;

    // Eight 80-pixel bars: index is Pixel_X / 80 built from threshold compares
    always_comb begin
        bar_c = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (Pixel_X >= CNT_W'(80 * k)) bar_c = 3'(k);
        end
    end

    always_comb begin
        src_color_c = 12'h000;
        case (bar_c)
            3'd0:    src_color_c = 12'hFFF;
            3'd1:    src_color_c = 12'hFF0;
            3'd2:    src_color_c = 12'h0FF;
            3'd3:    src_color_c = 12'h0F0;
            3'd4:    src_color_c = 12'hF0F;
            3'd5:    src_color_c = 12'hF00;
            3'd6:    src_color_c = 12'h00F;
            default: src_color_c = 12'h000;
        endcase
    end
`else
    assign src_color_c = Color_In;
`endif

    assign rgb_c = Pixel_Valid ? src_color_c : '0;

    // Stage 1: colour and syncs share one register stage so the pins stay aligned
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            RED    <= '0;
            GREEN  <= '0;
            BLUE   <= '0;
            H_Sync <= 1'b1;
            V_Sync <= 1'b1;
        end else if (Pix_En) begin
            {RED, GREEN, BLUE} <= rgb_c;
            H_Sync <= ~h_active_c;
            V_Sync <= ~v_active_c;
        end
    end

endmodule
